// File: rtl/rom_ctrl_access_arb.sv
// ROM port owner: the startup checker until chk_done_i, a one-cycle drain, then the bus for good.
// Optional bus stall counter is built when ROM_CTRL_ARB_STALL_CNT_EN is defined.
module rom_ctrl_access_arb #(
    parameter int AW = 4,
    parameter int DW = 40
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          chk_req_i,
    input  logic [AW-1:0] chk_addr_i,
    input  logic          chk_done_i,
    input  logic          bus_req_i,
    input  logic [AW-1:0] bus_addr_i,
    output logic          bus_gnt_o,
    output logic          bus_rvalid_o,
    output logic [DW-1:0] bus_rdata_o,
    output logic          rom_req_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_rdata_i,
    output logic          sel_bus_o,
    output logic          alert_o,
    output logic [15:0]   stall_cnt_o
);

    localparam logic [1:0] ST_CHECK    = 2'd0;
    localparam logic [1:0] ST_HANDOVER = 2'd1;
    localparam logic [1:0] ST_BUS      = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    logic [1:0] state_reg, state_next;
    logic       rvalid_reg;
    logic       alert_reg;
    logic       rdata_en;

    // Once chk_done_i has been seen high it must stay high; any fall is terminal.
    always_comb begin
        state_next = ST_ERROR;
        case (state_reg)
            ST_CHECK:    state_next = chk_done_i ? ST_HANDOVER : ST_CHECK;
            ST_HANDOVER: state_next = chk_done_i ? ST_BUS : ST_ERROR;
            ST_BUS:      state_next = chk_done_i ? ST_BUS : ST_ERROR;
            default:     state_next = ST_ERROR;
        endcase
    end

    always_comb begin
        bus_gnt_o  = 1'b0;
        rom_req_o  = 1'b0;
        rom_addr_o = '0;
        case (state_reg)
            ST_CHECK: begin
                rom_req_o  = chk_req_i;
                rom_addr_o = chk_addr_i;
            end
            ST_BUS: begin
                bus_gnt_o  = bus_req_i;
                rom_req_o  = bus_req_i;
                rom_addr_o = bus_addr_i;
            end
            default: begin
                bus_gnt_o  = 1'b0;
                rom_req_o  = 1'b0;
                rom_addr_o = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_CHECK;
            rvalid_reg <= 1'b0;
            alert_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rvalid_reg <= bus_req_i & bus_gnt_o;
            alert_reg  <= (state_next == ST_ERROR);
        end
    end

    // A read granted in the faulting cycle still completes, but with no ROM data.
    assign rdata_en = rvalid_reg & (state_reg != ST_ERROR);

    for (genvar gi = 0; gi < DW; gi++) begin : g_rdata
        assign bus_rdata_o[gi] = rdata_en & rom_rdata_i[gi];
    end

    assign bus_rvalid_o = rvalid_reg;
    assign sel_bus_o    = (state_reg == ST_BUS);
    assign alert_o      = alert_reg;

`ifdef ROM_CTRL_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= 16'h0;
        end else if (bus_req_i && !bus_gnt_o && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_rom_ctrl_access_arb.sv
// Bench for rom_ctrl_access_arb: directed scenarios plus randomized traffic checked against
// an ownership model based on how many cycles chk_done_i has been held high since reset.
module tb_rom_ctrl_access_arb;

    localparam int AW = 4;
    localparam int DW = 40;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          chk_req_i = 1'b0;
    logic [AW-1:0] chk_addr_i = '0;
    logic          chk_done_i = 1'b0;
    logic          bus_req_i = 1'b0;
    logic [AW-1:0] bus_addr_i = '0;
    logic          bus_gnt_o;
    logic          bus_rvalid_o;
    logic [DW-1:0] bus_rdata_o;
    logic          rom_req_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_rdata_i = '0;
    logic          sel_bus_o;
    logic          alert_o;
    logic [15:0]   stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: done_run = cycles chk_done_i sampled high since reset (0 check, 1 drain, >=2 bus).
    int  done_run = 0;
    bit  fault    = 1'b0;
    bit  pend     = 1'b0;
    int  stall_m  = 0;

    rom_ctrl_access_arb #(.AW(AW), .DW(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .chk_req_i    (chk_req_i),
        .chk_addr_i   (chk_addr_i),
        .chk_done_i   (chk_done_i),
        .bus_req_i    (bus_req_i),
        .bus_addr_i   (bus_addr_i),
        .bus_gnt_o    (bus_gnt_o),
        .bus_rvalid_o (bus_rvalid_o),
        .bus_rdata_o  (bus_rdata_o),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rdata_i  (rom_rdata_i),
        .sel_bus_o    (sel_bus_o),
        .alert_o      (alert_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_check();
        return !fault && done_run == 0;
    endfunction

    function automatic bit m_bus();
        return !fault && done_run >= 2;
    endfunction

    function automatic bit exp_gnt();
        return m_bus() && bus_req_i;
    endfunction

    function automatic bit exp_rom_req();
        if (m_check()) return chk_req_i;
        if (m_bus()) return bus_req_i;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] exp_rom_addr();
        if (m_check()) return chk_addr_i;
        if (m_bus()) return bus_addr_i;
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_rdata();
        return (pend && !fault) ? rom_rdata_i : '0;
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef ROM_CTRL_ARB_STALL_CNT_EN
        return 16'(stall_m);
`else
        return 16'h0;
`endif
    endfunction

    // Advance one clock edge and move the model with the inputs present at that edge.
    task automatic tick();
        bit g;
        g = exp_gnt();
        @(posedge clk_i);
        if (rst_i) begin
            done_run = 0; fault = 1'b0; pend = 1'b0; stall_m = 0;
        end else begin
            pend = g;
            if (bus_req_i && !g && stall_m < 65535) stall_m++;
            if (!fault) begin
                if (done_run > 0 && !chk_done_i) fault = 1'b1;
                else if (chk_done_i) done_run++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; chk_req_i = 1'b0; chk_done_i = 1'b0; bus_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_req_i = 1'b1; chk_addr_i = 4'd3;
        #1;
        n_checks++; if (rom_req_o !== 1'b1) begin n_fail++; $display("FAIL t1_rom_req: got %b want 1", rom_req_o); end
        n_checks++; if (rom_addr_o !== 4'd3) begin n_fail++; $display("FAIL t1_rom_addr: got %0d want 3", rom_addr_o); end
        n_checks++; if (bus_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t1_gnt: got %b want 0", bus_gnt_o); end
        n_checks++; if (alert_o !== 1'b0) begin n_fail++; $display("FAIL t1_alert: got %b want 0", alert_o); end
        n_checks++; if (sel_bus_o !== 1'b0) begin n_fail++; $display("FAIL t1_sel: got %b want 0", sel_bus_o); end
        n_checks++; if (bus_rvalid_o !== 1'b0 || bus_rdata_o !== '0) begin n_fail++; $display("FAIL t1_rvalid: got %b/%h want 0/0", bus_rvalid_o, bus_rdata_o); end
        n_checks++; if (stall_cnt_o !== 16'h0) begin n_fail++; $display("FAIL t1_stall: got %0d want 0", stall_cnt_o); end
        $display("test_reset done");
    endtask

    task automatic test_handover();
        chk_done_i = 1'b1; bus_req_i = 1'b1;
        #1;
        n_checks++; if (sel_bus_o !== 1'b0 || bus_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t2_n_state: got sel=%b gnt=%b want 0/0", sel_bus_o, bus_gnt_o); end
        tick();
        chk_req_i = 1'b1; chk_addr_i = 4'd9;
        #1;
        n_checks++; if (rom_req_o !== 1'b0 || rom_addr_o !== 4'd0) begin n_fail++; $display("FAIL t2_drain_rom: got %b/%0d want 0/0", rom_req_o, rom_addr_o); end
        n_checks++; if (bus_gnt_o !== 1'b0 || sel_bus_o !== 1'b0) begin n_fail++; $display("FAIL t2_drain_gnt: got gnt=%b sel=%b want 0/0", bus_gnt_o, sel_bus_o); end
        bus_req_i = 1'b0;
        tick();
        #1;
        n_checks++; if (sel_bus_o !== 1'b1) begin n_fail++; $display("FAIL t2_sel_bus: got %b want 1", sel_bus_o); end
        n_checks++; if (rom_req_o !== 1'b0) begin n_fail++; $display("FAIL t2_chk_ignored: got rom_req %b want 0", rom_req_o); end
        $display("test_handover done");
    endtask

    task automatic test_bus_read();
        logic [DW-1:0] d [3];
        chk_req_i = 1'b0;
        bus_req_i = 1'b1; bus_addr_i = 4'd5;
        #1;
        n_checks++; if (bus_gnt_o !== 1'b1 || rom_req_o !== 1'b1) begin n_fail++; $display("FAIL t3_gnt: got gnt=%b req=%b want 1/1", bus_gnt_o, rom_req_o); end
        n_checks++; if (rom_addr_o !== 4'd5) begin n_fail++; $display("FAIL t3_addr: got %0d want 5", rom_addr_o); end
        tick();
        bus_req_i = 1'b0; rom_rdata_i = 40'hA5;
        #1;
        n_checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 40'hA5) begin n_fail++; $display("FAIL t3_rdata: got %b/%h want 1/a5", bus_rvalid_o, bus_rdata_o); end
        tick();
        // back-to-back grants: one rvalid per grant, no bubbles
        bus_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_addr_i = 4'($urandom_range(0, 15));
            tick();
            d[i] = {8'($urandom), $urandom};
            rom_rdata_i = d[i];
            #1;
            n_checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== d[i]) begin n_fail++; $display("FAIL t3_b2b%0d: got %b/%h want 1/%h", i, bus_rvalid_o, bus_rdata_o, d[i]); end
        end
        bus_req_i = 1'b0;
        tick();
        #1;
        n_checks++; if (bus_rvalid_o !== 1'b0 || bus_rdata_o !== '0) begin n_fail++; $display("FAIL t3_idle: got %b/%h want 0/0", bus_rvalid_o, bus_rdata_o); end
        $display("test_bus_read done");
    endtask

    task automatic test_bus_fault();
        bus_req_i = 1'b1; bus_addr_i = 4'd2; chk_done_i = 1'b0;
        #1;
        n_checks++; if (bus_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t4_gnt: got %b want 1", bus_gnt_o); end
        tick();
        rom_rdata_i = 40'hFF_FFFF_FFFF;
        #1;
        n_checks++; if (alert_o !== 1'b1) begin n_fail++; $display("FAIL t4_alert: got %b want 1", alert_o); end
        n_checks++; if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== '0) begin n_fail++; $display("FAIL t4_rdata: got %b/%h want 1/0", bus_rvalid_o, bus_rdata_o); end
        n_checks++; if (bus_gnt_o !== 1'b0 || rom_req_o !== 1'b0 || sel_bus_o !== 1'b0) begin n_fail++; $display("FAIL t4_locked: got gnt=%b req=%b sel=%b want 0", bus_gnt_o, rom_req_o, sel_bus_o); end
        chk_done_i = 1'b1;
        tick();
        #1;
        n_checks++; if (alert_o !== 1'b1 || bus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t4_sticky: got alert=%b rvalid=%b want 1/0", alert_o, bus_rvalid_o); end
        $display("test_bus_fault done");
    endtask

    task automatic test_handover_glitch();
        do_reset();
        chk_done_i = 1'b1;
        tick();
        chk_done_i = 1'b0;
        tick();
        #1;
        n_checks++; if (alert_o !== 1'b1 || sel_bus_o !== 1'b0) begin n_fail++; $display("FAIL t5_alert: got alert=%b sel=%b want 1/0", alert_o, sel_bus_o); end
        do_reset();
        chk_req_i = 1'b1; chk_addr_i = 4'd7;
        #1;
        n_checks++; if (alert_o !== 1'b0 || rom_req_o !== 1'b1 || rom_addr_o !== 4'd7) begin n_fail++; $display("FAIL t5_recover: got alert=%b req=%b addr=%0d want 0/1/7", alert_o, rom_req_o, rom_addr_o); end
        $display("test_handover_glitch done");
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst_i      = ($urandom_range(0, 59) == 0);
            chk_done_i = chk_done_i ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 11) == 0);
            chk_req_i  = 1'($urandom);
            chk_addr_i = 4'($urandom);
            bus_req_i  = ($urandom_range(0, 3) != 0);
            bus_addr_i = 4'($urandom);
            rom_rdata_i = {8'($urandom), $urandom};
            #1;
            bad = 0;
            n_checks++; if (bus_gnt_o !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", i, bus_gnt_o, exp_gnt()); end
            n_checks++; if (rom_req_o !== exp_rom_req() || rom_addr_o !== exp_rom_addr()) begin bad++; $display("FAIL rnd_rom@%0d: got %b/%0d want %b/%0d", i, rom_req_o, rom_addr_o, exp_rom_req(), exp_rom_addr()); end
            n_checks++; if (bus_rvalid_o !== pend || bus_rdata_o !== exp_rdata()) begin bad++; $display("FAIL rnd_rdata@%0d: got %b/%h want %b/%h", i, bus_rvalid_o, bus_rdata_o, pend, exp_rdata()); end
            n_checks++; if (sel_bus_o !== m_bus() || alert_o !== fault) begin bad++; $display("FAIL rnd_state@%0d: got sel=%b alert=%b want %b/%b", i, sel_bus_o, alert_o, m_bus(), fault); end
            n_checks++; if (stall_cnt_o !== exp_stall()) begin bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall_cnt_o, exp_stall()); end
            n_fail += bad;
            tick();
        end
        rst_i = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_stall();
        do_reset();
        bus_req_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #1;
`ifdef ROM_CTRL_ARB_STALL_CNT_EN
        n_checks++; if (stall_cnt_o !== 16'd10) begin n_fail++; $display("FAIL t6_ten: got %0d want 10", stall_cnt_o); end
        for (int i = 0; i < 70000; i++) tick();
        #1;
        n_checks++; if (stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL t6_sat: got %h want ffff", stall_cnt_o); end
`else
        n_checks++; if (stall_cnt_o !== 16'h0) begin n_fail++; $display("FAIL t6_off: got %0d want 0", stall_cnt_o); end
`endif
        bus_req_i = 1'b0;
        $display("test_stall done");
    endtask

    initial begin
        test_reset();
        test_handover();
        test_bus_read();
        test_bus_fault();
        test_handover_glitch();
        test_random();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
